// File: rtl/csi2_raw10_unpacker_if.sv
// Bundle of the packet-handler-facing inputs and the pixel-beat outputs of
// the RAW10 unpacker. master = upstream / stimulus side, slave = unpacker.
interface csi2_raw10_unpacker_if;
  logic        short_pkt_valid_i;
  logic [5:0]  short_pkt_data_type_i;
  logic        long_pkt_header_valid_i;
  logic [5:0]  long_pkt_data_type_i;
  logic [15:0] long_pkt_word_cnt_i;
  logic [31:0] long_pkt_payload_i;
  logic        long_pkt_payload_valid_i;
  logic [3:0]  long_pkt_payload_be_i;
  logic [39:0] pix_o;
  logic        pix_valid_o;
  logic        pix_sof_o;
  logic        pix_eol_o;
  logic        fmt_err_o;

  modport master (
    output short_pkt_valid_i, short_pkt_data_type_i,
    output long_pkt_header_valid_i, long_pkt_data_type_i, long_pkt_word_cnt_i,
    output long_pkt_payload_i, long_pkt_payload_valid_i, long_pkt_payload_be_i,
    input  pix_o, pix_valid_o, pix_sof_o, pix_eol_o, fmt_err_o
  );

  modport slave (
    input  short_pkt_valid_i, short_pkt_data_type_i,
    input  long_pkt_header_valid_i, long_pkt_data_type_i, long_pkt_word_cnt_i,
    input  long_pkt_payload_i, long_pkt_payload_valid_i, long_pkt_payload_be_i,
    output pix_o, pix_valid_o, pix_sof_o, pix_eol_o, fmt_err_o
  );
endinterface

// File: rtl/csi2_raw10_unpacker.sv
// CSI-2 RAW10 unpacker: turns 5-byte groups of a RAW10 long-packet payload
// into beats of four 10-bit pixels, tagging start-of-frame and end-of-line.
// At most 8 bytes are ever held (4 residual + 4 new), so no backpressure.
module csi2_raw10_unpacker #(
  parameter logic [5:0] RAW10_DT = 6'h2B,
  parameter logic [5:0] FS_DT    = 6'h00
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  csi2_raw10_unpacker_if.slave  bus
);

  typedef enum logic {
    IDLE,
    LINE
  } state_t;

  state_t      state;
  logic [7:0]  byte_buf [8];
  logic [3:0]  buf_cnt;
  logic [15:0] bytes_left;
  logic        sof_pending;

  logic [39:0] pix_q;
  logic        pix_valid_q;
  logic        pix_sof_q;
  logic        pix_eol_q;
  logic        fmt_err_q;

  logic        fs_hit;
  logic        sof_now;
  logic        is_raw10;
  logic        wc_ok;
  logic [2:0]  be_cnt;
  logic        be_legal;
  logic [2:0]  take_n;
  logic [7:0]  merged [8];
  logic [3:0]  pos;
  logic [3:0]  fill;
  logic        emit;
  logic [15:0] left_next;
  logic [39:0] pix_next;

  assign bus.pix_o       = pix_q;
  assign bus.pix_valid_o = pix_valid_q;
  assign bus.pix_sof_o   = pix_sof_q;
  assign bus.pix_eol_o   = pix_eol_q;
  assign bus.fmt_err_o   = fmt_err_q;

  // A Frame Start arriving together with the completing word still tags that beat.
  assign fs_hit   = bus.short_pkt_valid_i && (bus.short_pkt_data_type_i == FS_DT);
  assign sof_now  = sof_pending | fs_hit;
  assign is_raw10 = (bus.long_pkt_data_type_i == RAW10_DT);
  assign wc_ok    = (bus.long_pkt_word_cnt_i != 16'd0) &&
                    ((bus.long_pkt_word_cnt_i % 16'd5) == 16'd0);

  // Decode byte enables: only LSB-contiguous patterns are legal.
  always_comb begin
    be_cnt   = 3'd0;
    be_legal = 1'b1;
    case (bus.long_pkt_payload_be_i)
      4'b0000: be_cnt = 3'd0;
      4'b0001: be_cnt = 3'd1;
      4'b0011: be_cnt = 3'd2;
      4'b0111: be_cnt = 3'd3;
      4'b1111: be_cnt = 3'd4;
      default: be_legal = 1'b0;
    endcase
  end

  // Clamp the accepted byte count to what remains of the line.
  always_comb begin
    if ({13'd0, be_cnt} > bytes_left) take_n = bytes_left[2:0];
    else                              take_n = be_cnt;
  end

  // Append the accepted bytes behind the residual ones.
  always_comb begin
    merged = byte_buf;
    pos    = 4'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      pos = buf_cnt + 4'(i);
      if ((3'(i) < take_n) && (pos < 4'd8))
        merged[pos[2:0]] = bus.long_pkt_payload_i[8*i +: 8];
    end
  end

  assign fill      = buf_cnt + {1'b0, take_n};
  assign emit      = (fill >= 4'd5);
  assign left_next = bytes_left - {13'd0, take_n};

  // Byte 4 of each group carries the two LSBs of all four pixels.
  assign pix_next = {merged[3], merged[4][7:6],
                     merged[2], merged[4][5:4],
                     merged[1], merged[4][3:2],
                     merged[0], merged[4][1:0]};

  // Line FSM, byte buffer and registered beat outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      byte_buf    <= '{default: '0};
      buf_cnt     <= '0;
      bytes_left  <= '0;
      sof_pending <= 1'b0;
      pix_q       <= '0;
      pix_valid_q <= 1'b0;
      pix_sof_q   <= 1'b0;
      pix_eol_q   <= 1'b0;
      fmt_err_q   <= 1'b0;
    end else begin
      pix_valid_q <= 1'b0;
      pix_sof_q   <= 1'b0;
      pix_eol_q   <= 1'b0;
      fmt_err_q   <= 1'b0;
      if (fs_hit) sof_pending <= 1'b1;

      if (bus.long_pkt_header_valid_i) begin
        // Header wins over any payload in the same cycle; an unfinished line is aborted.
        if ((state == LINE) && (bytes_left != 16'd0)) fmt_err_q <= 1'b1;
        buf_cnt <= '0;
        if (is_raw10 && wc_ok) begin
          bytes_left <= bus.long_pkt_word_cnt_i;
          state      <= LINE;
        end else begin
          if (is_raw10) fmt_err_q <= 1'b1;
          bytes_left <= '0;
          state      <= IDLE;
        end
      end else if (bus.long_pkt_payload_valid_i && (state == LINE)) begin
        if (!be_legal) begin
          fmt_err_q  <= 1'b1;
          buf_cnt    <= '0;
          bytes_left <= '0;
          state      <= IDLE;
        end else begin
          bytes_left <= left_next;
          if (emit) begin
            pix_q       <= pix_next;
            pix_valid_q <= 1'b1;
            pix_sof_q   <= sof_now;
            pix_eol_q   <= (left_next == 16'd0);
            sof_pending <= 1'b0;
            byte_buf[0] <= merged[5];
            byte_buf[1] <= merged[6];
            byte_buf[2] <= merged[7];
            buf_cnt     <= fill - 4'd5;
            // Word counts are multiples of 5, so the line always ends on a beat.
            if (left_next == 16'd0) state <= IDLE;
          end else begin
            byte_buf <= merged;
            buf_cnt  <= fill;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_csi2_raw10_unpacker.sv
// Self-checking bench for csi2_raw10_unpacker: directed cases with literal
// expectations plus randomized packet traffic against a byte-queue model.
module tb_csi2_raw10_unpacker;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  csi2_raw10_unpacker_if bus();

  csi2_raw10_unpacker #(
    .RAW10_DT(6'h2B),
    .FS_DT   (6'h00)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model state
  bit          m_line;
  int          m_left;
  byte unsigned m_q[$];
  bit          m_sof;
  bit          e_valid, e_sof, e_eol, e_err;
  logic [39:0] e_pix;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_line = 0; m_left = 0; m_q.delete(); m_sof = 0;
    e_valid = 0; e_sof = 0; e_eol = 0; e_err = 0; e_pix = '0;
  endtask

  task automatic model_step();
    bit fs, sofn, beat;
    int n, px;
    logic [3:0]  be;
    logic [31:0] d;
    byte unsigned b[5];
    beat = 0; e_err = 0; e_eol = 0;
    be = bus.long_pkt_payload_be_i;
    d  = bus.long_pkt_payload_i;
    fs = bus.short_pkt_valid_i && (bus.short_pkt_data_type_i == 6'h00);
    sofn = m_sof || fs;
    if (bus.long_pkt_header_valid_i) begin
      if (m_line && m_left != 0) e_err = 1;
      m_q.delete();
      if (bus.long_pkt_data_type_i == 6'h2B && bus.long_pkt_word_cnt_i != 0 &&
          (int'(bus.long_pkt_word_cnt_i) % 5) == 0) begin
        m_line = 1; m_left = int'(bus.long_pkt_word_cnt_i);
      end else begin
        if (bus.long_pkt_data_type_i == 6'h2B) e_err = 1;
        m_line = 0; m_left = 0;
      end
    end else if (bus.long_pkt_payload_valid_i && m_line) begin
      if (!(be inside {4'h0, 4'h1, 4'h3, 4'h7, 4'hF})) begin
        e_err = 1; m_line = 0; m_left = 0; m_q.delete();
      end else begin
        n = $countones(be);
        if (n > m_left) n = m_left;
        for (int i = 0; i < n; i++) m_q.push_back(d[8*i +: 8]);
        m_left -= n;
        if (m_q.size() >= 5) begin
          for (int k = 0; k < 5; k++) b[k] = m_q.pop_front();
          for (int k = 0; k < 4; k++) begin
            px = int'(b[k]) * 4 + ((int'(b[4]) >> (2 * k)) & 3);
            e_pix[10*k +: 10] = 10'(px);
          end
          beat = 1;
          e_eol = (m_left == 0);
          if (e_eol) m_line = 0;
        end
      end
    end
    e_valid = beat;
    e_sof = beat && sofn;
    m_sof = beat ? 1'b0 : sofn;
  endtask

  // Model advances on the same events as the DUT registers.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Cycle-by-cycle comparison away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("pix_valid", 64'(bus.pix_valid_o), 64'(e_valid));
        chk("pix_sof",   64'(bus.pix_sof_o),   64'(e_sof));
        chk("pix_eol",   64'(bus.pix_eol_o),   64'(e_eol));
        chk("fmt_err",   64'(bus.fmt_err_o),   64'(e_err));
        if (e_valid) chk("pix", 64'(bus.pix_o), 64'(e_pix));
      end
    end
  end

  task automatic cyc(input bit hv, input logic [5:0] dt, input logic [15:0] wc,
                     input bit pv, input logic [31:0] d, input logic [3:0] be,
                     input bit sv, input logic [5:0] sdt);
    bus.long_pkt_header_valid_i  = hv;
    bus.long_pkt_data_type_i     = dt;
    bus.long_pkt_word_cnt_i      = wc;
    bus.long_pkt_payload_valid_i = pv;
    bus.long_pkt_payload_i       = d;
    bus.long_pkt_payload_be_i    = be;
    bus.short_pkt_valid_i        = sv;
    bus.short_pkt_data_type_i    = sdt;
    @(negedge clk);
    bus.long_pkt_header_valid_i  = 1'b0;
    bus.long_pkt_payload_valid_i = 1'b0;
    bus.short_pkt_valid_i        = 1'b0;
  endtask

  task automatic hdr(input logic [5:0] dt, input logic [15:0] wc);
    cyc(1'b1, dt, wc, 1'b0, 32'h0, 4'h0, 1'b0, 6'h0);
  endtask

  task automatic word(input logic [31:0] d, input logic [3:0] be);
    cyc(1'b0, 6'h0, 16'h0, 1'b1, d, be, 1'b0, 6'h0);
  endtask

  task automatic short_pkt(input logic [5:0] dt);
    cyc(1'b0, 6'h0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b1, dt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 6'h0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b0, 6'h0);
  endtask

  localparam logic [39:0] BEAT1 = {10'h013, 10'h00E, 10'h009, 10'h004};
  localparam logic [39:0] BEAT2 = {10'h020, 10'h01D, 10'h01A, 10'h017};
  localparam logic [39:0] BEAT3 = {10'h013, 10'h00F, 10'h00B, 10'h007};

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r, nw, x;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic [3:0]  be;

    bus.long_pkt_header_valid_i  = 1'b0;
    bus.long_pkt_data_type_i     = '0;
    bus.long_pkt_word_cnt_i      = '0;
    bus.long_pkt_payload_valid_i = 1'b0;
    bus.long_pkt_payload_i       = '0;
    bus.long_pkt_payload_be_i    = '0;
    bus.short_pkt_valid_i        = 1'b0;
    bus.short_pkt_data_type_i    = '0;

    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_pix", 64'(bus.pix_o), 64'h0);
    chk("reset_valid", 64'(bus.pix_valid_o), 64'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Frame Start then basic line
    short_pkt(6'h00);
    hdr(6'h2B, 16'd10);
    word(32'h04030201, 4'hF);
    chk("basic_no_beat_yet", 64'(bus.pix_valid_o), 64'h0);
    word(32'h070605E4, 4'hF);
    chk("basic_b1_valid", 64'(bus.pix_valid_o), 64'h1);
    chk("basic_b1_pix",   64'(bus.pix_o), 64'(BEAT1));
    chk("basic_b1_sof",   64'(bus.pix_sof_o), 64'h1);
    chk("basic_b1_eol",   64'(bus.pix_eol_o), 64'h0);
    word(32'h00001B08, 4'h3);
    chk("basic_b2_pix",   64'(bus.pix_o), 64'(BEAT2));
    chk("basic_b2_sof",   64'(bus.pix_sof_o), 64'h0);
    chk("basic_b2_eol",   64'(bus.pix_eol_o), 64'h1);
    idle(1);

    // Following line carries no sof
    hdr(6'h2B, 16'd10);
    word(32'h04030201, 4'hF);
    word(32'h070605E4, 4'hF);
    chk("line2_b1_sof", 64'(bus.pix_sof_o), 64'h0);
    word(32'h00001B08, 4'h3);
    chk("line2_b2_sof", 64'(bus.pix_sof_o), 64'h0);
    idle(1);

    // Bad word count
    hdr(6'h2B, 16'd7);
    chk("badwc_err", 64'(bus.fmt_err_o), 64'h1);
    word(32'h04030201, 4'hF);
    chk("badwc_err_once", 64'(bus.fmt_err_o), 64'h0);
    word(32'h070605E4, 4'hF);
    chk("badwc_no_beat", 64'(bus.pix_valid_o), 64'h0);
    idle(1);

    // Non-RAW10 packet
    hdr(6'h2C, 16'd8);
    chk("nonraw_err", 64'(bus.fmt_err_o), 64'h0);
    word(32'h11223344, 4'hF);
    word(32'h55667788, 4'hF);
    chk("nonraw_no_beat", 64'(bus.pix_valid_o), 64'h0);
    idle(1);

    // Aborted line
    hdr(6'h2B, 16'd10);
    word(32'hAABBCCDD, 4'hF);
    hdr(6'h2B, 16'd5);
    chk("abort_err", 64'(bus.fmt_err_o), 64'h1);
    word(32'h04030201, 4'hF);
    chk("abort_err_once", 64'(bus.fmt_err_o), 64'h0);
    word(32'h000000FF, 4'h1);
    chk("abort_pix", 64'(bus.pix_o), 64'(BEAT3));
    chk("abort_eol", 64'(bus.pix_eol_o), 64'h1);
    idle(1);

    // Illegal byte enable drops the line
    hdr(6'h2B, 16'd10);
    word(32'h04030201, 4'b0101);
    chk("badbe_err", 64'(bus.fmt_err_o), 64'h1);
    word(32'h070605E4, 4'hF);
    word(32'h00001B08, 4'h3);
    chk("badbe_no_beat", 64'(bus.pix_valid_o), 64'h0);
    idle(1);

    // Reset while a beat is on the outputs
    hdr(6'h2B, 16'd10);
    word(32'h04030201, 4'hF);
    word(32'h070605E4, 4'hF);
    chk("rst_pre_valid", 64'(bus.pix_valid_o), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(bus.pix_valid_o), 64'h0);
    chk("rst_async_pix",   64'(bus.pix_o), 64'h0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    word(32'h00001B08, 4'h3);
    chk("rst_post_no_beat", 64'(bus.pix_valid_o), 64'h0);
    idle(1);

    // Randomized traffic
    for (int p = 0; p < 120; p++) begin
      r = $urandom_range(0, 99);
      if (r < 25) short_pkt(6'h00);
      else if (r < 30) short_pkt(6'($urandom_range(1, 3)));
      dt = ($urandom_range(0, 99) < 80) ? 6'h2B : 6'($urandom_range(0, 63));
      wc = ($urandom_range(0, 99) < 85) ? 16'(5 * $urandom_range(1, 10))
                                        : 16'($urandom_range(0, 40));
      if ($urandom_range(0, 9) == 0)
        cyc(1'b1, dt, wc, 1'b1, $urandom, 4'hF, 1'b0, 6'h0);
      else
        hdr(dt, wc);
      nw = (int'(wc) + 3) / 4 + $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) nw = nw / 2;
      for (int w = 0; w < nw; w++) begin
        x = $urandom_range(0, 99);
        be = (x < 70) ? 4'hF : (x < 78) ? 4'h7 : (x < 86) ? 4'h3 :
             (x < 94) ? 4'h1 : (x < 97) ? 4'h0 : 4'b0110;
        cyc(1'b0, 6'h0, 16'h0, 1'b1, $urandom, be,
            ($urandom_range(0, 19) == 0), 6'h00);
        if ($urandom_range(0, 4) == 0) idle(1);
      end
      idle($urandom_range(0, 2));
    end

    idle(3);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
